// File: rtl/sseg_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sseg_scan_driver_pkg
// Description : Shared constants for the four-digit seven-segment scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package sseg_scan_driver_pkg;

    // Field positions inside one packed digit byte
    localparam int unsigned SEG_MSB = 7;
    localparam int unsigned SEG_LSB = 1;
    localparam int unsigned DP_BIT  = 0;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_on   = 2'd1;
    localparam logic [1:0] c_st_gap  = 2'd2;

    localparam logic [3:0]  c_an_off    = 4'hF;
    localparam logic [6:0]  c_seg_off   = 7'h7F;
    localparam logic        c_dp_off    = 1'b1;
    localparam logic [31:0] c_frame_off = 32'hFFFF_FFFF;

    // A terminal count of zero still needs a one-bit counter
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_scan_driver_digit_mux.sv
`default_nettype none
// ============================================================================
// Module      : sseg_digit_mux
// Description : Selects the scanned digit byte and applies blank/blink gating.
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_digit_mux
    import sseg_scan_driver_pkg::*;
(
    input  logic [31:0] frame,
    input  logic [1:0]  index,
    input  logic        lit,
    input  logic        blank,
    input  logic        blink_off,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    logic [7:0] w_byte;

    always_comb begin
        w_byte = frame[{index, 3'b000} +: 8];
        an     = c_an_off;
        seg    = c_seg_off;
        dp     = c_dp_off;
        if (lit && !blank && !blink_off) begin
            an  = ~(4'b0001 << index);
            seg = w_byte[SEG_MSB:SEG_LSB];
            dp  = w_byte[DP_BIT];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : sseg_scan_driver
// Description : Time-multiplexed 4-digit 7-segment scanner with tear-free
//               frame update, anti-ghosting gaps, blanking and blinking.
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_scan_driver
    import sseg_scan_driver_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GAP_CYCLES  = 16,
    parameter int unsigned BLINK_SLOTS = 250
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] sevenSeg,
    input  logic        load,
    input  logic        blank,
    input  logic        blink_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int unsigned c_on_w    = cnt_width(REFRESH_DIV);
    localparam int unsigned c_gap_w   = cnt_width(GAP_CYCLES);
    localparam int unsigned c_blink_w = cnt_width(BLINK_SLOTS);

    localparam logic [c_on_w-1:0]    c_on_last    = c_on_w'(REFRESH_DIV - 1);
    localparam logic [c_gap_w-1:0]   c_gap_last   = c_gap_w'(GAP_CYCLES - 1);
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_SLOTS - 1);

    logic [1:0]           r_state;
    logic [1:0]           r_index;
    logic [c_on_w-1:0]    r_on_cnt;
    logic [c_gap_w-1:0]   r_gap_cnt;
    logic [c_blink_w-1:0] r_blink_cnt;
    logic                 r_phase;
    logic                 r_pend_vld;
    logic [31:0]          r_pend;
    logic [31:0]          r_active;
    logic                 r_frame_done;

    logic w_frame_end;
    logic w_wrap;

    assign w_frame_end = (r_state == c_st_on) && (r_on_cnt == c_on_last) && (r_index == 2'd0);
    assign w_wrap      = w_frame_end && (r_blink_cnt == c_blink_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_index      <= 2'd3;
            r_on_cnt     <= '0;
            r_gap_cnt    <= '0;
            r_blink_cnt  <= '0;
            r_phase      <= 1'b0;
            r_pend_vld   <= 1'b0;
            r_pend       <= c_frame_off;
            r_active     <= c_frame_off;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (load) begin
                r_pend     <= sevenSeg;
                r_pend_vld <= 1'b1;
            end

            // r_index names the digit of the current/next ON slot; it steps
            // down when a slot ends so the first slot after IDLE is index 3.
            case (r_state)
                c_st_idle: begin
                    if (load) begin
                        r_state   <= c_st_gap;
                        r_index   <= 2'd3;
                        r_gap_cnt <= '0;
                        r_active  <= sevenSeg;
                    end
                end
                c_st_on: begin
                    if (r_on_cnt == c_on_last) begin
                        r_on_cnt <= '0;
                        r_state  <= c_st_gap;
                        r_index  <= r_index - 2'd1;
                    end else begin
                        r_on_cnt <= r_on_cnt + 1'b1;
                    end
                end
                c_st_gap: begin
                    if (r_gap_cnt == c_gap_last) begin
                        r_gap_cnt <= '0;
                        r_state   <= c_st_on;
                        if (r_index == 2'd3 && r_pend_vld) begin
                            r_active <= r_pend;
                            if (!load) begin
                                r_pend_vld <= 1'b0;
                            end
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase

            if (w_frame_end) begin
                r_blink_cnt <= w_wrap ? '0 : r_blink_cnt + 1'b1;
            end
            if (!blink_en) begin
                r_phase <= 1'b0;
            end else if (w_wrap) begin
                r_phase <= ~r_phase;
            end
        end
    end

    assign frame_done = r_frame_done;

    sseg_digit_mux u_mux (
        .frame     (r_active),
        .index     (r_index),
        .lit       (r_state == c_st_on),
        .blank     (blank),
        .blink_off (blink_en && r_phase),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_sseg_scan_driver
// Description : Scoreboard bench; reference model derives each cycle's
//               display from the frame timeline and the last-loaded values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_driver;

    localparam int REFRESH_DIV = 4;
    localparam int GAP_CYCLES  = 1;
    localparam int BLINK_SLOTS = 2;
    localparam int SLOT        = REFRESH_DIV + GAP_CYCLES;
    localparam int FRAME       = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] sevenSeg = 32'h0;
    logic        load = 1'b0;
    logic        blank = 1'b0;
    logic        blink_en = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t  q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    string tag = "reset";

    // model state
    bit          started = 0;
    int          mdl_m = 0;
    logic [31:0] pend = '1;
    logic [31:0] disp = '1;
    int          fd_count = 0;
    bit          phase = 0;

    sseg_scan_driver #(
        .REFRESH_DIV (REFRESH_DIV),
        .GAP_CYCLES  (GAP_CYCLES),
        .BLINK_SLOTS (BLINK_SLOTS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sevenSeg   (sevenSeg),
        .load       (load),
        .blank      (blank),
        .blink_en   (blink_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: mdl_m counts edges since the first load; the frame is
    // a fixed 20-cycle pattern of (gap, lit) slots for digits 3,2,1,0.
    initial begin
        exp_t       e;
        int         u;
        int         d;
        bit         fd_now;
        logic [3:0] one_hot;
        forever begin
            @(posedge clk);
            fd_now = 0;
            if (!rst_n) begin
                started  = 0;
                mdl_m    = 0;
                pend     = '1;
                disp     = '1;
                fd_count = 0;
                phase    = 0;
            end else begin
                if (started) begin
                    mdl_m++;
                    if (mdl_m % FRAME == GAP_CYCLES) disp = pend;
                    if (mdl_m % FRAME == 0) begin
                        fd_now = 1;
                        fd_count++;
                    end
                end else if (load) begin
                    started = 1;
                    mdl_m   = 0;
                    disp    = sevenSeg;
                end
                if (load) pend = sevenSeg;
                if (!blink_en) phase = 0;
                else if (fd_now && (fd_count % BLINK_SLOTS == 0)) phase = !phase;
            end
            e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};
            if (rst_n && started) begin
                u    = mdl_m % FRAME;
                d    = 3 - u / SLOT;
                e.fd = fd_now;
                if ((u % SLOT) >= GAP_CYCLES && !blank && !(blink_en && phase)) begin
                    one_hot = 4'b0001 << d;
                    e.an    = ~one_hot;
                    e.seg   = disp[8*d+1 +: 7];
                    e.dp    = disp[8*d];
                end
            end
            q.push_back(e);
        end
    end

    // Monitor: one expected entry per clock, checked mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL %s: scoreboard empty at t=%0t", tag, $time);
            end else begin
                e = q.pop_front();
                if ({an, seg, dp, frame_done} !== {e.an, e.seg, e.dp, e.fd}) begin
                    n_bad++;
                    $display("FAIL %s t=%0t: got an=%b seg=%h dp=%b fd=%b, expected an=%b seg=%h dp=%b fd=%b",
                             tag, $time, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
                end
            end
        end
    end

    task automatic step(input bit ld, input logic [31:0] v);
        @(negedge clk);
        #1;
        load = ld;
        if (ld) sevenSeg = v;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 32'h0);
    endtask

    task automatic wait_pos(input int pos);
        int k;
        k = 0;
        while ((mdl_m % FRAME) != pos && k < 200) begin
            step(0, 32'h0);
            k++;
        end
        if (k >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timeout waiting for frame position %0d (at %0d)", tag, pos, mdl_m % FRAME);
        end
    endtask

    initial begin
        idle(3);
        rst_n = 1'b1;
        tag = "reset_idle";
        idle(50);

        tag = "frame_0123";
        step(1, 32'h81F3_4860);
        idle(80);

        tag = "midframe_load";
        wait_pos(12);
        step(1, 32'h0101_0101);
        idle(45);

        tag = "swap_cycle_load";
        wait_pos(12);
        step(1, 32'hC0F9_A4B0);
        wait_pos(0);
        step(1, 32'h9924_1279);
        idle(60);

        tag = "random_loads";
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 11) == 0, $urandom());
            if ($urandom_range(0, 29) == 0) blank = ~blank;
        end
        blank = 1'b0;

        tag = "blink";
        blink_en = 1'b1;
        for (int i = 0; i < 220; i++) begin
            step($urandom_range(0, 19) == 0, $urandom());
        end

        tag = "blink_blank";
        for (int i = 0; i < 120; i++) begin
            step(0, 32'h0);
            if ($urandom_range(0, 9) == 0) blank = ~blank;
            if ($urandom_range(0, 39) == 0) blink_en = ~blink_en;
        end
        blink_en = 1'b0;

        tag = "blank";
        blank = 1'b1;
        idle(60);
        blank = 1'b0;

        tag = "reset_mid";
        wait_pos(7);
        step(1, 32'h1234_5678);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(20);

        tag = "restart";
        step(1, 32'h8888_0000 | ($urandom() & 32'h0000_FFFF));
        idle(50);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
